// File: rtl/dotprod_ctrl_pkg.sv
// Shared constants for the dotprod run controller: FSM state codes, SRAM port owner codes, default widths.
package dotprod_ctrl_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_ABORT = 2'd3;

  // Who drives an SRAM port this cycle.
  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_HOST = 2'd1;
  localparam logic [1:0] OWN_KERN = 2'd2;

endpackage

// File: rtl/dotprod_ctrl_sram_port_mux.sv
// Single-port SRAM request mux: host load, kernel passthrough or idle zeros.
// Purely combinational, zero latency; no backpressure (owner chosen by the FSM).
module sram_port_mux
  import dotprod_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        own_i,
  input  logic              host_vld_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_dat_i,
  input  logic [ADDR_W-1:0] kern_addr_i,
  input  logic [DATA_W-1:0] kern_dat_i,
  input  logic              kern_ce_i,
  input  logic              kern_we_i,
  output logic [ADDR_W-1:0] address0_o,
  output logic [DATA_W-1:0] d0_o,
  output logic              ce0_o,
  output logic              we0_o
);

  always_comb begin
    address0_o = '0;
    d0_o       = '0;
    ce0_o      = 1'b0;
    we0_o      = 1'b0;
    case (own_i)
      OWN_HOST: begin
        address0_o = host_addr_i;
        d0_o       = host_dat_i;
        ce0_o      = host_vld_i;
        we0_o      = host_vld_i;
      end
      OWN_KERN: begin
        address0_o = kern_addr_i;
        d0_o       = kern_dat_i;
        ce0_o      = kern_ce_i;
        we0_o      = kern_we_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dotprod_ctrl.sv
// Run controller for the dotprod kernel: host loads SRAMs a/b, go starts the kernel, result on res_valid/res_ready.
// go to k_ap_start is 1 cycle; HOLD stalls on res_ready; DOTPROD_CTRL_TIMEOUT_EN adds a RUN watchdog and ABORT state.
module dotprod_ctrl
  import dotprod_ctrl_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              go,
  input  logic [31:0]       n_in,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              err,
  output logic              k_ap_start,
  input  logic              k_ap_done,
  input  logic              k_ap_idle,
  input  logic [DATA_W-1:0] k_ap_return,
  output logic [31:0]       k_n,
  output logic              k_rst_n,
  input  logic [ADDR_W-1:0] k_a_address0,
  input  logic [DATA_W-1:0] k_a_ad0,
  input  logic              k_a_ce0,
  input  logic              k_a_we0,
  input  logic [ADDR_W-1:0] k_b_address0,
  input  logic [DATA_W-1:0] k_b_ad0,
  input  logic              k_b_ce0,
  input  logic              k_b_we0,
  output logic [ADDR_W-1:0] a_address0,
  output logic [DATA_W-1:0] a_d0,
  output logic              a_ce0,
  output logic              a_we0,
  output logic [ADDR_W-1:0] b_address0,
  output logic [DATA_W-1:0] b_d0,
  output logic              b_ce0,
  output logic              b_we0
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [31:0]       k_n_q, k_n_d;
  logic [1:0]        a_own, b_own;
  logic              kern_idle_unused;

  assign kern_idle_unused = k_ap_idle;

`ifdef DOTPROD_CTRL_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_q, tmo_d;
  logic        ab_q, ab_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    k_n_d      = k_n_q;
`ifdef DOTPROD_CTRL_TIMEOUT_EN
    tmo_d      = tmo_q;
    ab_d       = ab_q;
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          k_n_d = n_in;
`ifdef DOTPROD_CTRL_TIMEOUT_EN
          err_d = 1'b0;
          tmo_d = '0;
`endif
          // Zero-length run completes without ever starting the kernel.
          if (n_in == 32'd0) begin
            res_data_d = '0;
            state_d    = ST_HOLD;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (k_ap_done) begin
          res_data_d = k_ap_return;
          state_d    = ST_HOLD;
        end
`ifdef DOTPROD_CTRL_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d    = ST_ABORT;
          err_d      = 1'b1;
          res_data_d = '0;
          ab_d       = 1'b0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
`endif
      end
      ST_HOLD: begin
        if (res_ready) state_d = ST_IDLE;
      end
`ifdef DOTPROD_CTRL_TIMEOUT_EN
      ST_ABORT: begin
        // Two-cycle kernel reset pulse, tracked by ab_q.
        ab_d = 1'b1;
        if (ab_q) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= ST_IDLE;
      res_data_q <= '0;
      k_n_q      <= '0;
`ifdef DOTPROD_CTRL_TIMEOUT_EN
      tmo_q      <= '0;
      ab_q       <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      k_n_q      <= k_n_d;
`ifdef DOTPROD_CTRL_TIMEOUT_EN
      tmo_q      <= tmo_d;
      ab_q       <= ab_d;
      err_q      <= err_d;
`endif
    end
  end

  always_comb begin
    a_own = OWN_IDLE;
    b_own = OWN_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (ld_sel) b_own = OWN_HOST;
        else        a_own = OWN_HOST;
      end
      ST_RUN: begin
        a_own = OWN_KERN;
        b_own = OWN_KERN;
      end
      default: ;
    endcase
  end

  sram_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux_a (
    .own_i       (a_own),
    .host_vld_i  (ld_valid),
    .host_addr_i (ld_addr),
    .host_dat_i  (ld_data),
    .kern_addr_i (k_a_address0),
    .kern_dat_i  (k_a_ad0),
    .kern_ce_i   (k_a_ce0),
    .kern_we_i   (k_a_we0),
    .address0_o  (a_address0),
    .d0_o        (a_d0),
    .ce0_o       (a_ce0),
    .we0_o       (a_we0)
  );

  sram_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux_b (
    .own_i       (b_own),
    .host_vld_i  (ld_valid),
    .host_addr_i (ld_addr),
    .host_dat_i  (ld_data),
    .kern_addr_i (k_b_address0),
    .kern_dat_i  (k_b_ad0),
    .kern_ce_i   (k_b_ce0),
    .kern_we_i   (k_b_we0),
    .address0_o  (b_address0),
    .d0_o        (b_d0),
    .ce0_o       (b_ce0),
    .we0_o       (b_we0)
  );

  assign ld_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign res_valid  = (state_q == ST_HOLD);
  assign k_ap_start = (state_q == ST_RUN);
  assign res_data   = res_data_q;
  assign k_n        = k_n_q;

`ifdef DOTPROD_CTRL_TIMEOUT_EN
  assign err     = err_q;
  assign k_rst_n = ~ap_rst & (state_q != ST_ABORT);
`else
  assign err     = 1'b0;
  assign k_rst_n = ~ap_rst;
`endif

endmodule
